// File: rtl/font_rom_arbiter.sv
// Shares one registered-address 2048x8 font ROM among N requesters.
// Aged, optional fixed-priority and round-robin grant; in-order responses two cycles after grant.
module font_rom_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned PRIO0    = 1,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N-1:0]      req,
    input  logic [N*11-1:0]   addr,
    output logic [N-1:0]      gnt,
    output logic [N-1:0]      rsp_valid,
    output logic [7:0]        rsp_data,
    output logic [10:0]       rom_addr,
    input  logic [7:0]        rom_data
);

    localparam int unsigned AW = 11;
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    localparam int unsigned IW = (N > 2) ? $clog2(N) : 1;

    logic [IW-1:0]         ptr_q, ptr_d;
    logic [N-1:0][WW-1:0]  wait_q, wait_d;
    logic [AW-1:0]         rom_addr_q, rom_addr_d;
    logic                  tag_vld_q, tag_vld_d;
    logic [IW-1:0]         tag_idx_q, tag_idx_d;
    logic [N-1:0]          rsp_valid_q, rsp_valid_d;

    logic                  win_vld;
    logic                  win_rr;
    logic [IW-1:0]         win_idx;

    // Winner selection: aged first, then requester 0 if prioritised, then round-robin from ptr.
    always_comb begin
        int rr_idx;
        win_vld = 1'b0;
        win_rr  = 1'b0;
        win_idx = '0;
        rr_idx  = 0;
        gnt     = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i] && (wait_q[i] == WW'(MAX_WAIT))) begin
                win_vld = 1'b1;
                win_idx = IW'(i);
            end
        end
        if (!win_vld && (PRIO0 != 0) && req[0]) begin
            win_vld = 1'b1;
            win_idx = '0;
        end
        if (!win_vld) begin
            // Descending scan so the requester closest to ptr is assigned last.
            for (int k = int'(N) - 1; k >= 0; k--) begin
                rr_idx = int'(ptr_q) + k;
                if (rr_idx >= int'(N)) begin
                    rr_idx = rr_idx - int'(N);
                end
                if (req[rr_idx]) begin
                    win_vld = 1'b1;
                    win_rr  = 1'b1;
                    win_idx = IW'(rr_idx);
                end
            end
        end
        if (!reset_n) begin
            win_vld = 1'b0;
            win_rr  = 1'b0;
        end
        if (win_vld) begin
            gnt[win_idx] = 1'b1;
        end
    end

    // Next-state: pointer, wait counters and the two pipeline tag stages.
    always_comb begin
        ptr_d       = ptr_q;
        wait_d      = wait_q;
        rom_addr_d  = rom_addr_q;
        tag_vld_d   = win_vld;
        tag_idx_d   = win_idx;
        rsp_valid_d = '0;
        if (win_vld && win_rr) begin
            ptr_d = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
        end
        for (int i = 0; i < int'(N); i++) begin
            if (!req[i] || gnt[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != WW'(MAX_WAIT)) begin
                wait_d[i] = wait_q[i] + WW'(1);
            end
        end
        if (win_vld) begin
            rom_addr_d = addr[AW*win_idx +: AW];
        end
        if (tag_vld_q) begin
            rsp_valid_d[tag_idx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            wait_q      <= '0;
            rom_addr_q  <= '0;
            tag_vld_q   <= 1'b0;
            tag_idx_q   <= '0;
            rsp_valid_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            wait_q      <= wait_d;
            rom_addr_q  <= rom_addr_d;
            tag_vld_q   <= tag_vld_d;
            tag_idx_q   <= tag_idx_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rom_data;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: directed scenarios plus random traffic against a
// queue-based response scoreboard and a rule-level grant model.
module tb_font_rom_arbiter;

    localparam int N        = 4;
    localparam int PRIO0    = 1;
    localparam int MAX_WAIT = 15;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req;
    logic [N*11-1:0]   addr;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rsp_valid;
    logic [7:0]        rsp_data;
    logic [10:0]       rom_addr;
    logic [7:0]        rom_data;

    font_rom_arbiter #(.N(N), .PRIO0(PRIO0), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rom_addr(rom_addr),
        .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    logic [7:0] rom_mem [2048];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    typedef struct {
        int         idx;
        logic [7:0] data;
        longint     due;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    longint     cyc = 0;
    int         wcnt[N];
    int         rr;
    int         rsp3_cnt = 0;
    logic [N-1:0] last_gnt;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Grant rule: aged lowest index, then requester 0 if prioritised, then first from rr pointer.
    function automatic int model_pick(input logic [N-1:0] r, output bit by_rr);
        by_rr = 0;
        for (int i = 0; i < N; i++)
            if (r[i] && wcnt[i] == MAX_WAIT) return i;
        if (PRIO0 != 0 && r[0]) return 0;
        for (int k = 0; k < N; k++) begin
            int j = (rr + k) % N;
            if (r[j]) begin
                by_rr = 1;
                return j;
            end
        end
        return -1;
    endfunction

    // Monitor: compares responses and grants, then advances the model across the next edge.
    always @(negedge clk) begin
        exp_t e;
        bit   by_rr;
        int   g;
        if (!reset_n) begin
            chk("gnt_in_reset", gnt, 0);
            chk("rsp_valid_in_reset", rsp_valid, 0);
            sb_q.delete();
            rr = 0;
            for (int i = 0; i < N; i++) wcnt[i] = 0;
        end else begin
            if (rsp_valid != 0) begin
                if (rsp_valid[3]) rsp3_cnt++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_valid", rsp_valid, longint'(1) << e.idx);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_cycle", cyc, e.due);
                end
            end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                chk("missing_rsp", rsp_valid, longint'(1) << sb_q[0].idx);
                void'(sb_q.pop_front());
            end
            g = model_pick(req, by_rr);
            chk("gnt", gnt, (g < 0) ? 0 : (longint'(1) << g));
            if (g >= 0) begin
                e.idx  = g;
                e.data = rom_mem[addr[11*g +: 11]];
                e.due  = cyc + 2;
                sb_q.push_back(e);
                if (by_rr) rr = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (req[i] && i != g) wcnt[i] = (wcnt[i] < MAX_WAIT) ? wcnt[i] + 1 : MAX_WAIT;
                else wcnt[i] = 0;
            end
        end
        cyc++;
    end

    task automatic step(input logic [N-1:0] r, input logic [N*11-1:0] a);
        req  = r;
        addr = a;
        @(negedge clk);
        last_gnt = gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic count_ref(input int who, input logic [N-1:0] r, output int n);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            step(r, addr);
            if (last_gnt[who]) break;
            n++;
        end
    endtask

    initial begin
        logic [N*11-1:0] av;
        int n;
        int rr_exp [6];
        for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
        rom_mem[11'h014] = 8'hA9;
        rom_mem[11'h7f4] = 8'h10;
        rom_mem[11'h7f5] = 8'h38;
        rom_mem[11'h7f6] = 8'h6C;
        rom_mem[11'h7f7] = 8'hC6;

        // Reset with a request pending: grant must stay low.
        reset_n = 1'b0;
        req     = 4'b0100;
        addr    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("gnt_reset_gated", gnt, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        req     = '0;
        chk("rom_addr_reset", rom_addr, 0);
        chk("rsp_valid_reset", rsp_valid, 0);

        // Single lookup by requester 2.
        av = '0;
        av[22 +: 11] = 11'h014;
        step(4'b0100, av);
        chk("single_gnt", last_gnt, 4'b0100);
        chk("single_rom_addr", rom_addr, 11'h014);
        repeat (3) step('0, '0);

        // Back-to-back lookups by requester 3.
        for (int k = 0; k < 4; k++) begin
            av = '0;
            av[33 +: 11] = 11'(11'h7f4 + k);
            step(4'b1000, av);
        end
        repeat (3) step('0, '0);
        chk("b2b_rsp3_count", rsp3_cnt, 4);

        // Requester 1 starved by prioritised requester 0 until aged.
        av = '0;
        av[0 +: 11]  = 11'h100;
        av[11 +: 11] = 11'h205;
        addr = av;
        count_ref(1, 4'b0011, n);
        chk("aged_refusals", n, MAX_WAIT);
        step(4'b0011, av);
        chk("prio_resumes", last_gnt, 4'b0001);
        step('0, '0);

        // Requester 2 withdraws after 3 refusals; its age must restart from zero.
        av[22 +: 11] = 11'h333;
        for (int k = 0; k < 3; k++) begin
            step(4'b0101, av);
            chk("drop_no_gnt2", last_gnt[2], 0);
        end
        step(4'b0001, av);
        addr = av;
        count_ref(2, 4'b0101, n);
        chk("drop_wait_cleared", n, MAX_WAIT);
        repeat (3) step('0, '0);

        // Reset right after an accepting edge discards the in-flight lookup.
        av = '0;
        av[11 +: 11] = 11'h123;
        step(4'b0010, av);
        reset_n = 1'b0;
        @(negedge clk);
        chk("gnt_mid_reset", gnt, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        req = '0;
        repeat (3) step('0, '0);
        av[11 +: 11] = 11'h0AA;
        step(4'b0010, av);
        chk("post_reset_gnt1", last_gnt, 4'b0010);

        // Round-robin among 1..3 starting from pointer 2.
        rr_exp = '{2, 3, 1, 2, 3, 1};
        av = {11'h7f7, 11'h7f5, 11'h014, 11'h000};
        for (int k = 0; k < 6; k++) begin
            step(4'b1110, av);
            chk("rr_order", last_gnt, longint'(1) << rr_exp[k]);
        end
        repeat (3) step('0, '0);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] r;
            r  = N'($urandom) | N'($urandom);
            av = {12'($urandom), 32'($urandom)};
            step(r, av);
        end
        repeat (4) step('0, '0);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/font_rom_arbiter.md
Name: font_rom_arbiter

Overview:
- Shares one single-port 2048x8 character font ROM among N text-overlay requesters, e.g. score, logo, rules and game-over text generators in the Pong display path.
- Each ROM address is {char_code[6:0], row[3:0]}. The ROM registers its address internally, so data appears the cycle after the address is latched.
- The block arbitrates requests, drives the ROM address, and returns each 8-bit row bitmap to the requester that asked for it. Ordering is in-order, throughput is one lookup per clock, and aging bounds the worst-case wait.

Parameters:
- N, 4: number of requesters (2..8).
- PRIO0, 1: 1 = requester 0 (live pixel path) has fixed priority over round-robin; 0 = pure round-robin.
- MAX_WAIT, 15: cycles a pending requester may be refused before it is forced to win (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  N  per-requester lookup request, level.
- addr  in  N*11  packed request addresses; slice i = addr[11*i+10:11*i].
- gnt  out  N  one-hot grant, combinational; transfer occurs on an edge where req[i]&gnt[i].
- rsp_valid  out  N  one-hot, registered; high for exactly one cycle per accepted request.
- rsp_data  out  8  row bitmap; valid only while any rsp_valid is high.
- rom_addr  out  11  registered address to the font ROM.
- rom_data  in  8  ROM output, valid the cycle after rom_addr is latched by the ROM.

Behaviour:
- Reset (async assert, sync release):
  - rom_addr=0, rsp_valid=0, RR pointer=0, all wait counters=0, pipeline tags cleared.
  - gnt=0 while reset_n low.
  - Reset mid-operation discards in-flight lookups; no rsp_valid is ever produced for a pre-reset acceptance.
- Handshake:
  - Requester holds addr stable while req high and gnt low.
  - gnt is at most one-hot and never asserted to a requester with req low.
  - A requester may keep req high with a new addr each cycle for back-to-back lookups.
- Grant selection (combinational from req and registered state), in priority order:
  - (1) Aged: lowest index i with req[i] and wait[i]==MAX_WAIT.
  - (2) If PRIO0=1 and req[0], then requester 0.
  - (3) Round-robin: first req[i] searching from pointer, wrapping N-1 to 0.
- RR pointer: updates to (i+1) mod N only when the grant came from step (3). Aged or priority grants leave it unchanged.
- Wait counters, per requester:
  - Increment (saturating at MAX_WAIT) each edge where req[i]&!gnt[i].
  - Clear on a grant edge or when req[i] is low.
- Pipeline (E0 = accepting edge):
  - E0: rom_addr<=addr slice of the winner; stage-1 tag<={valid, index}.
  - E1: the ROM latches rom_addr; stage-2 tag<=stage-1 tag.
  - Cycle after E1: rsp_valid[index]=1 and rsp_data=rom_data (pass-through).
  - Response is 2 cycles after the req/gnt cycle. Throughput is 1/clk.
- No accepting edge: rom_addr holds its value and a bubble tag propagates, so rsp_valid=0 in the corresponding cycle.
- No backpressure on responses: the requester must accept rsp_data in its rsp_valid cycle.
- Simultaneous events:
  - A requester may be granted in the same cycle its previous response is valid.
  - Multiple aged requesters: lowest index wins; the others keep saturated counters and win in later cycles.
- Widths: the wait counter is clog2(MAX_WAIT+1) bits; the index tag is clog2(N) bits (minimum 1).

Test Plan:
- Reset, then single req[2] with addr 11'h014 (ROM 8'b10101001) → gnt[2] same cycle; rom_addr=11'h014 after E0; rsp_valid=4'b0100, rsp_data=8'hA9 two cycles after the req cycle; no other rsp_valid.
- PRIO0=0, req=4'b1111 held with fixed addresses → grants cycle 0,1,2,3,0…, one per clock; responses in the same order with matching data.
- PRIO0=1, req[0] held continuously, req[1] held → req[1] refused for exactly MAX_WAIT=15 cycles, granted on the 16th, then req[0] resumes; wait[1] returns to 0.
- Back-to-back: req[3] high for 4 cycles with addresses 11'h7f4..11'h7f7 → four consecutive rsp_valid[3] pulses with data 8'h10, 8'h38, 8'h6C, 8'hC6.
- Assert reset_n low one cycle after an accepting edge → all rsp_valid stay 0 through and after reset release; RR pointer=0; the next req[1] receives the expected first response.
- Requester drops req before grant (req[2] high 3 refused cycles, then low) → wait[2] clears, no rsp_valid[2] generated, gnt[2] never asserted.
